// File: rtl/flag_sequencer.sv
// Status-flag controller for the MEH16 core: Z/S refresh, arbitrated carry commit,
// flag save/restore stack and a branch-condition evaluator with a ready/valid handshake.
//
// Carry FSM states:
//   state    | meaning
//   IDLE     | no carry-producing op outstanding
//   PEND_ALU | ALU op issued last cycle, C takes alu_c_flag this cycle
//   PEND_A   | A-unit op issued last cycle, C takes a_c_flag this cycle
module flag_sequencer #(
    parameter int STACK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a_out,
    input  logic        alu_op,
    input  logic        alu_c_flag,
    input  logic        a_op,
    input  logic        a_c_flag,
    input  logic        save,
    input  logic        restore,
    input  logic        cond_valid,
    input  logic [2:0]  cond,
    output logic        cond_ready,
    output logic        taken_valid,
    output logic        taken,
    output logic [2:0]  flags,
    output logic        stack_err
);

    localparam int SP_W = $clog2(STACK_DEPTH) + 1;
    localparam int IDX_W = SP_W - 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PEND_ALU,
        PEND_A
    } carry_state_t;

    carry_state_t state, state_next;

    logic [SP_W-1:0]  sp;
    logic [SP_W-1:0]  sp_m1;
    logic [2:0]       stack_mem [STACK_DEPTH];
    logic             push_ok;
    logic             pop_ok;
    logic             stack_fault;
    logic             c_next;
    logic [2:0]       flags_next;
    logic             accept;
    logic             cond_result;

    assign sp_m1       = sp - 1'b1;
    assign push_ok     = save && !restore && (sp != SP_FULL);
    assign pop_ok      = restore && !save && (sp != '0);
    assign stack_fault = (save && !restore && (sp == SP_FULL))
                      || (restore && !save && (sp == '0));

    assign cond_ready  = (state == IDLE) && !restore;
    assign accept      = cond_valid && cond_ready;

    // A new op always wins the next state, so back-to-back ops need no special case.
    always_comb begin
        state_next = IDLE;
        c_next     = flags[1];
        case (state)
            PEND_ALU: c_next = alu_c_flag;
            PEND_A:   c_next = a_c_flag;
            default:  c_next = flags[1];
        endcase
        if (alu_op) begin
            state_next = PEND_ALU;
        end else if (a_op) begin
            state_next = PEND_A;
        end
    end

    always_comb begin
        flags_next = {a_out[15], c_next, (a_out == 16'h0000)};
        if (pop_ok) begin
            flags_next = stack_mem[sp_m1[IDX_W-1:0]];
        end
    end

    always_comb begin
        cond_result = 1'b0;
        case (cond)
            3'b000:  cond_result = 1'b1;
            3'b001:  cond_result = flags[0];
            3'b010:  cond_result = !flags[0];
            3'b011:  cond_result = flags[1];
            3'b100:  cond_result = !flags[1];
            3'b101:  cond_result = flags[2];
            3'b110:  cond_result = !flags[2];
            default: cond_result = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            flags       <= 3'b001;
            sp          <= '0;
            stack_err   <= 1'b0;
            taken       <= 1'b0;
            taken_valid <= 1'b0;
        end else begin
            state       <= state_next;
            flags       <= flags_next;
            taken_valid <= accept;
            if (accept) begin
                taken <= cond_result;
            end
            if (push_ok) begin
                sp <= sp + 1'b1;
            end else if (pop_ok) begin
                sp <= sp_m1;
            end
            if (stack_fault) begin
                stack_err <= 1'b1;
            end
        end
    end

    // Stack contents are left unreset; only sp defines which slots are live.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            stack_mem[sp[IDX_W-1:0]] <= flags;
        end
    end

endmodule
